// File: rtl/sad_min_search.sv
// Sums one row of PE abs-differences per beat, accumulates ROWS beats into a candidate SAD and keeps
// the minimum and its motion vector. Define EARLY_TERM_EN to add the cand_reject early-rejection output.
module sad_min_search #(
   parameter int PIXEL  = 8,
   parameter int NUM_PE = 8,
   parameter int ROWS   = 8,
   parameter int SAD_W  = 14,
   parameter int MV_W   = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_PE*PIXEL-1:0]   abs_in,
   input  logic                      abs_valid,
   input  logic signed [MV_W-1:0]    cand_x,
   input  logic signed [MV_W-1:0]    cand_y,
   input  logic                      cand_last,
   input  logic                      search_start,
   output logic                      busy,
   output logic                      done,
   output logic [SAD_W-1:0]          best_sad,
   output logic signed [MV_W-1:0]    best_mv_x,
`ifdef EARLY_TERM_EN
   output logic signed [MV_W-1:0]    best_mv_y,
   output logic                      cand_reject
`else
   output logic signed [MV_W-1:0]    best_mv_y
`endif
);

   localparam int SUM_W = PIXEL + $clog2(NUM_PE);
   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;
   state_t state, state_nxt;

   function automatic logic [SUM_W-1:0] row_total(input logic [NUM_PE*PIXEL-1:0] v);
      logic [SUM_W-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_PE; i++)
         s = s + SUM_W'(v[i*PIXEL +: PIXEL]);
      return s;
   endfunction

   logic                     accept;
   logic [CNT_W-1:0]         row_cnt;
   logic                     vld_p1, first_p1, wrap_p1, last_p1;
   logic [SUM_W-1:0]         row_sum_p1;
   logic signed [MV_W-1:0]   mv_x_p1, mv_y_p1;
   logic                     cmp_vld_p2, last_p2;
   logic [SAD_W-1:0]         acc_p2, acc_nxt;
   logic signed [MV_W-1:0]   mv_x_p2, mv_y_p2;
   logic                     keep_p2;

   always_comb accept = abs_valid && (state == ST_SEARCH);
   always_comb acc_nxt = first_p1 ? SAD_W'(row_sum_p1) : acc_p2 + SAD_W'(row_sum_p1);

   // stage 1: row sum; row index flags and MV travel with the beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         row_cnt <= '0;
      end else begin
         vld_p1 <= accept;
         if (state == ST_IDLE && search_start)
            row_cnt <= '0;
         else if (accept)
            row_cnt <= (row_cnt == CNT_W'(ROWS-1)) ? '0 : row_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         row_sum_p1 <= row_total(abs_in);
         first_p1   <= (row_cnt == '0);
         wrap_p1    <= (row_cnt == CNT_W'(ROWS-1));
         mv_x_p1    <= cand_x;
         mv_y_p1    <= cand_y;
         last_p1    <= cand_last;
      end
   end

   // stage 2: accumulate; the wrap beat marks the candidate complete
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cmp_vld_p2 <= 1'b0;
      else
         cmp_vld_p2 <= vld_p1 && wrap_p1;
   end

   always_ff @(posedge clk) begin
      if (vld_p1) begin
         acc_p2 <= acc_nxt;
         if (first_p1) begin
            mv_x_p2 <= mv_x_p1;
            mv_y_p2 <= mv_y_p1;
            last_p2 <= last_p1;
         end
      end
   end

`ifdef EARLY_TERM_EN
   logic rej_p2, rej_set;
   // comparing against a best_sad that is about to shrink only delays a reject, never makes it wrong
   always_comb rej_set = vld_p1 && !wrap_p1 && !(rej_p2 && !first_p1) && (acc_nxt >= best_sad);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rej_p2      <= 1'b0;
         cand_reject <= 1'b0;
      end else begin
         if (vld_p1)
            rej_p2 <= first_p1 ? rej_set : (rej_p2 | rej_set);
         cand_reject <= rej_set;
      end
   end
   always_comb keep_p2 = !rej_p2;
`else
   always_comb keep_p2 = 1'b1;
`endif

   // stage 3: strict-less compare keeps the earlier candidate on a tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_sad  <= '0;
         best_mv_x <= '0;
         best_mv_y <= '0;
         busy      <= 1'b0;
      end else begin
         if (state == ST_IDLE && search_start) begin
            best_sad  <= '1;
            best_mv_x <= '0;
            best_mv_y <= '0;
            busy      <= 1'b1;
         end else if (state == ST_SEARCH && cmp_vld_p2 && keep_p2 && acc_p2 < best_sad) begin
            best_sad  <= acc_p2;
            best_mv_x <= mv_x_p2;
            best_mv_y <= mv_y_p2;
         end else if (state == ST_DONE) begin
            busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (search_start) state_nxt = ST_SEARCH;
         ST_SEARCH: if (cmp_vld_p2 && last_p2) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb done = (state == ST_DONE);

endmodule

// File: tb/tb_sad_min_search.sv
// Bench for sad_min_search: table of directed searches, reset corner cases, and random searches
// checked against a min-of-sums reference model.
module tb_sad_min_search;
   localparam int PIXEL = 8, NUM_PE = 8, ROWS = 8, SAD_W = 14, MV_W = 7;
   localparam int NB = NUM_PE * ROWS;

   logic clk = 1'b0;
   logic rst, abs_valid, cand_last, search_start;
   logic [NUM_PE*PIXEL-1:0] abs_in;
   logic signed [MV_W-1:0] cand_x, cand_y;
   logic busy, done;
   logic [SAD_W-1:0] best_sad;
   logic signed [MV_W-1:0] best_mv_x, best_mv_y;

`ifdef EARLY_TERM_EN
   logic cand_reject;
   int rej_cnt = 0;
   always @(posedge clk) if (cand_reject) rej_cnt++;
`endif

   sad_min_search #(.PIXEL(PIXEL), .NUM_PE(NUM_PE), .ROWS(ROWS), .SAD_W(SAD_W), .MV_W(MV_W)) dut (
      .clk(clk), .rst(rst), .abs_in(abs_in), .abs_valid(abs_valid),
      .cand_x(cand_x), .cand_y(cand_y), .cand_last(cand_last), .search_start(search_start),
      .busy(busy), .done(done), .best_sad(best_sad), .best_mv_x(best_mv_x),
`ifdef EARLY_TERM_EN
      .best_mv_y(best_mv_y), .cand_reject(cand_reject)
`else
      .best_mv_y(best_mv_y)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int abs_v[4][NB];
   int mvx_v[4], mvy_v[4];

   typedef struct {
      string name;
      int    n;
      int    sad[4];
      int    mx[4];
      int    my[4];
      int    gap;
      int    e_sad, e_x, e_y;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic void fill(input int c, input int sad);
      for (int i = 0; i < NB; i++) abs_v[c][i] = sad / NB + ((i < sad % NB) ? 1 : 0);
   endfunction

   task automatic drive_beat(input int c, input int r, input int last, input int gapmax);
      repeat ($urandom_range(gapmax, 0)) begin
         @(negedge clk);
         abs_valid    = 1'b0;
         abs_in       = {$urandom, $urandom};
         search_start = ($urandom_range(3, 0) == 0);
      end
      @(negedge clk);
      search_start = 1'b0;
      abs_valid    = 1'b1;
      for (int p = 0; p < NUM_PE; p++) abs_in[p*PIXEL +: PIXEL] = PIXEL'(abs_v[c][r*NUM_PE+p]);
      cand_x    = (r == 0) ? MV_W'(mvx_v[c]) : MV_W'($urandom);
      cand_y    = (r == 0) ? MV_W'(mvy_v[c]) : MV_W'($urandom);
      cand_last = (r == 0) ? (last != 0) : 1'($urandom);
   endtask

   task automatic start_search();
      repeat (2) begin
         @(negedge clk);
         abs_valid = 1'b1;
         abs_in    = {$urandom, $urandom};
      end
      @(negedge clk);
      abs_valid    = 1'b0;
      search_start = 1'b1;
      @(negedge clk);
      search_start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic run_search(input string name, input int n, input int gapmax,
                             input int e_sad, input int e_x, input int e_y);
      int lat;
      start_search();
      for (int c = 0; c < n; c++)
         for (int r = 0; r < ROWS; r++) drive_beat(c, r, (c == n-1) ? 1 : 0, gapmax);
      @(negedge clk);
      abs_valid = 1'b0;
      lat = 1;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, 3);
      chk({name, "_sad"}, best_sad, e_sad);
      chk({name, "_mvx"}, best_mv_x, e_x);
      chk({name, "_mvy"}, best_mv_y, e_y);
      chk({name, "_busy_at_done"}, busy, 1);
      @(negedge clk);
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_busy_after"}, busy, 0);
      chk({name, "_sad_hold"}, best_sad, e_sad);
   endtask

   task automatic set_vec(input int i, input string nm, input int n, input int s0, input int s1,
                          input int s2, input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int gap, input int es, input int ex, input int ey);
      vecs[i].name = nm;  vecs[i].n = n;  vecs[i].gap = gap;
      vecs[i].sad[0] = s0; vecs[i].sad[1] = s1; vecs[i].sad[2] = s2; vecs[i].sad[3] = 0;
      vecs[i].mx[0] = x0;  vecs[i].mx[1] = x1;  vecs[i].mx[2] = x2;  vecs[i].mx[3] = 0;
      vecs[i].my[0] = y0;  vecs[i].my[1] = y1;  vecs[i].my[2] = y2;  vecs[i].my[3] = 0;
      vecs[i].e_sad = es;  vecs[i].e_x = ex;    vecs[i].e_y = ey;
   endtask

   initial begin
      int exp_sad, exp_x, exp_y, s, n;
      set_vec(0, "one_cand",  1, 64,    0,   0,   3, -2, 0, 0,  0, 0,  0, 64,    3, -2);
      set_vec(1, "three",     3, 300,   120, 200, 0, 0,  1, 0,  2, 0,  0, 120,   1, 0);
      set_vec(2, "tie",       2, 100,   100, 0,  -1, 5,  4, 4,  0, 0,  0, 100,  -1, 5);
      set_vec(3, "max",       1, 16320, 0,   0,   5, 6,  0, 0,  0, 0,  0, 16320, 5, 6);
      set_vec(4, "max_gaps",  1, 16320, 0,   0,   5, 6,  0, 0,  0, 0,  3, 16320, 5, 6);
      set_vec(5, "desc_tie",  3, 50,    40,  40, -64, 63, 7, -7, 1, 1, 2, 40,    7, -7);

      rst = 1'b1; abs_valid = 1'b0; search_start = 1'b0; cand_last = 1'b0;
      abs_in = '0; cand_x = '0; cand_y = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sad", best_sad, 0);
      chk("rst_mvx", best_mv_x, 0);
      chk("rst_mvy", best_mv_y, 0);
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         for (int c = 0; c < vecs[v].n; c++) begin
            fill(c, vecs[v].sad[c]);
            mvx_v[c] = vecs[v].mx[c];
            mvy_v[c] = vecs[v].my[c];
         end
         run_search(vecs[v].name, vecs[v].n, vecs[v].gap, vecs[v].e_sad, vecs[v].e_x, vecs[v].e_y);
      end

      // reset in the middle of a candidate discards the search
      fill(0, 192);
      mvx_v[0] = 9; mvy_v[0] = 9;
      start_search();
      for (int r = 0; r < 4; r++) drive_beat(0, r, 1, 0);
      @(negedge clk);
      abs_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_sad", best_sad, 0);
      chk("midrst_mvx", best_mv_x, 0);
      chk("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      fill(0, 128);
      mvx_v[0] = -3; mvy_v[0] = 2;
      run_search("after_rst", 1, 0, 128, -3, 2);

      // candidate 2 rows sum to 10 each so its running total reaches 50 on beat 5
      fill(0, 50);
      for (int i = 0; i < NB; i++) abs_v[1][i] = (i % NUM_PE == 3) ? 10 : 0;
      mvx_v[0] = 1; mvy_v[0] = 1; mvx_v[1] = 2; mvy_v[1] = 2;
`ifdef EARLY_TERM_EN
      s = rej_cnt;
`endif
      run_search("early_term", 2, 0, 50, 1, 1);
`ifdef EARLY_TERM_EN
      chk("early_term_rejects", rej_cnt - s, 1);
`endif

      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(4, 1);
         exp_sad = (1 << SAD_W) - 1; exp_x = 0; exp_y = 0;
         for (int c = 0; c < n; c++) begin
            int lim;
            lim = $urandom_range(255, 0);
            for (int i = 0; i < NB; i++) abs_v[c][i] = $urandom_range(lim, 0);
            if (t == 0 && c == 1) abs_v[c] = abs_v[0];
            mvx_v[c] = $urandom_range(127, 0) - 64;
            mvy_v[c] = $urandom_range(127, 0) - 64;
            s = 0;
            foreach (abs_v[c][i]) s += abs_v[c][i];
            if (s < exp_sad) begin
               exp_sad = s; exp_x = mvx_v[c]; exp_y = mvy_v[c];
            end
         end
         run_search($sformatf("rand%0d", t), n, $urandom_range(2, 0), exp_sad, exp_x, exp_y);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Consumer end of the PE array's difference path: takes one abs-difference beat per cycle from a row of NUM_PE processing elements.
- Sums each beat through a registered adder tree and accumulates ROWS beats into one candidate SAD.
- Compares every completed candidate against the running minimum and tracks the winning motion vector.
- Sits between the PE array and the motion-vector output / mode-decision logic.

Parameters:
- PIXEL, 8, width of each abs-difference value.
- NUM_PE, 8, number of PE abs outputs per beat.
- ROWS, 8, beats accumulated per candidate.
- SAD_W, 14, SAD width; must satisfy 2^SAD_W-1 > NUM_PE*ROWS*(2^PIXEL-1).
- MV_W, 7, signed two's-complement MV component width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- abs_in  in  NUM_PE*PIXEL  packed PE abs outputs; PE0 in bits [PIXEL-1:0].
- abs_valid  in  1  abs_in beat valid.
- cand_x  in  MV_W  candidate MV x; sampled on the candidate's first beat.
- cand_y  in  MV_W  candidate MV y; sampled on the candidate's first beat.
- cand_last  in  1  sampled on first beat; marks the final candidate of the search.
- search_start  in  1  one-cycle pulse; begins a new search.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse; best_* final.
- best_sad  out  SAD_W  minimum SAD found.
- best_mv_x  out  MV_W  MV x of minimum.
- best_mv_y  out  MV_W  MV y of minimum.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and pipeline valids 0. Applies immediately, including mid-search; any partial search is discarded.
- States:
  - IDLE: search_start -> SEARCH. On that edge: best_sad <= all ones, best_mv <= 0, row_cnt <= 0, busy <= 1.
  - SEARCH: accepts beats. After the cand_last candidate completes its compare -> DONE.
  - DONE: done=1 for exactly one cycle, busy <= 0, -> IDLE.
- Ignored inputs: abs_valid outside SEARCH; search_start while SEARCH or DONE.
- Stage 1: when abs_valid in SEARCH, row_sum <= unsigned sum of the NUM_PE values, computed at full width with no truncation. The beat's row index, first-beat flag, MV and last flag travel with it.
- Stage 2: row_cnt==0 beat loads acc <= row_sum; other beats add acc <= acc+row_sum. row_cnt wraps ROWS-1 -> 0, and the wrap marks the candidate complete.
- Stage 3: a completed candidate with acc < best_sad (strict) updates best_sad and best_mv. On a tie the earlier candidate is kept.
- Gaps: abs_valid may deassert between any beats; valid bits hold pipeline state and nothing advances without a beat.
- Latency: last beat of the last candidate sampled at end of cycle T -> best_* final and done=1 during cycle T+3.
- Back-to-back: back-to-back candidates need no idle cycles.
- Overflow: SAD_W sizing guarantees no overflow; no saturation logic.
- Search with zero beats: FSM stays in SEARCH until reset or a cand_last candidate completes.

Optional Feature:
- Macro EARLY_TERM_EN.
- Defined:
  - After each accumulate, if acc >= best_sad and the candidate is not yet complete, a reject flag is set for that candidate.
  - The extra output port cand_reject (1 bit) pulses high one cycle, in the cycle after the flag sets, once per candidate.
  - A rejected candidate still consumes all ROWS beats but never updates best_*.
  - cand_reject never fires on the first candidate of a search (best_sad all ones).
- Undefined: the port and logic are absent; every candidate is fully compared.
- best_* results are identical either way.

Test Plan:
- search_start, one candidate (cand_x=3, cand_y=-2, cand_last=1), 8 beats all abs=1 -> done at T+3, best_sad=64, best_mv=(3,-2), busy falls with done.
- Three candidates with SADs 300, 120, 200 at MVs (0,0), (1,0), (2,0), sent back-to-back -> best_sad=120, best_mv=(1,0), single done pulse.
- Tie: two candidates, SAD 100 each, MVs (-1,5) then (4,4) -> best_mv=(-1,5).
- All abs=255 for one candidate -> best_sad=16320, no wrap; random abs_valid gaps give the same result as the gapless run.
- rst pulsed after 4 beats of a candidate -> outputs 0, busy=0; a later search with all abs=2 gives best_sad=128.
- EARLY_TERM_EN: candidate 1 SAD 50, candidate 2 beats of 10 each -> cand_reject pulses once after beat 5 of candidate 2 (acc 50 >= 50), best_sad stays 50.
